pwm_fan_driver: RTL and testbench
=================================

Name: pwm_fan_driver

Overview:
Output stage directly downstream of the PID controller core. Converts the controller's signed (ADC_BITWIDTH+1)-bit output into a saturated unsigned duty cycle and drives the fan PWM pin. Duty updates are glitch-free: the new duty is applied only at PWM period boundaries. A spin-up state machine forces full duty for a programmable number of periods whenever the fan starts from stop.

Parameters:
ADC_BITWIDTH, 8, duty resolution; the PWM period is 2^ADC_BITWIDTH-1 ticks.
CLK_DIV, 4, system clocks per PWM tick (>=1).
KICK_PERIODS, 16, full-duty spin-up periods on start (0 = no kick).
MIN_DUTY, 20, saturated duty below this value is treated as "fan off" (stall avoidance).

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
enable_i  in  1  fan enable; low forces OFF
value_i  in  ADC_BITWIDTH+1 (signed)  controller output, sampled only at period boundary
pwm_o  out  1  fan PWM drive, registered
duty_o  out  ADC_BITWIDTH  currently applied duty
period_end_o  out  1  one-clock strobe on the last clock of each PWM period
state_o  out  2  00 OFF, 01 KICK, 10 RUN

Behaviour:
- Reset is asynchronous and active-low on rstn_i, with a single clock clk_i. In reset, all registers clear: pwm_o=0, duty_o=0, period_end_o=0, state_o=OFF, prescaler=0, period counter=0, kick counter=0.
- Timebase runs freely in every state:
  - prescaler counts 0..CLK_DIV-1; tick = (prescaler==CLK_DIV-1).
  - period counter cnt counts 0..P-1 on each tick, where P=2^ADC_BITWIDTH-1, then wraps to 0.
- Boundary condition: tick && cnt==P-1. period_end_o is registered and is high for exactly the one clock in which this condition holds. Period length = CLK_DIV*P clocks.
- Saturation: sat = 0 if value_i<0, else value_i[ADC_BITWIDTH-1:0]. The max, 2^N-1, is full-on.
- want_on = enable_i && sat>=MIN_DUTY.
- FSM transitions are evaluated on the boundary clock edge. The new state and duty take effect from cnt=0.
  - OFF: duty=0. If want_on and KICK_PERIODS>0: go to KICK, kick_cnt=KICK_PERIODS-1, duty=2^N-1. If want_on and KICK_PERIODS==0: go to RUN, duty=sat.
  - KICK: duty stays 2^N-1. On each boundary, if kick_cnt!=0 then decrement. If kick_cnt==0: go to RUN with duty=sat when want_on, else go to OFF with duty=0.
  - RUN: on each boundary, duty=sat if want_on, else go to OFF with duty=0.
- enable_i low overrides boundary timing. In any state, on the next clock: state=OFF, duty_o=0, pwm_o=0. The timebase is not reset. Re-enabling waits for the next boundary and always passes through KICK.
- value_i changes between boundaries have no effect.
- pwm_o is a register kept equal to (cnt<duty) for the cnt/duty values held in the same cycle. This gives:
  - duty 0: pwm_o constantly low.
  - duty 2^N-1: pwm_o constantly high.
  - duty d: high for exactly d*CLK_DIV clocks per period.
- period_end_o may drive the PID clock-enable, so one control update occurs per PWM period.
- Reset asserted mid-period clears everything asynchronously. After release, the first boundary occurs CLK_DIV*P clocks later.

Decomposition:
- Shared package holds state encodings (OFF/KICK/RUN) and the P = 2^ADC_BITWIDTH-1 constant function.
- One sub-module, pwm_timebase: prescaler plus period counter. Outputs tick, cnt and boundary.
- FSM, saturation and compare stay in pwm_fan_driver.

Test Plan:
Use CLK_DIV=1, ADC_BITWIDTH=8, KICK_PERIODS=2, MIN_DUTY=20 unless noted.
1. Reset mid-period with enable_i=1, value_i=100: after release, state stays OFF until the first boundary (255 clocks). period_end_o pulses on clock 255.
2. Startup: enable_i=1, value_i=100 → 2 periods of pwm_o constantly high (state KICK), then RUN with duty_o=100. pwm_o is high for 100 of every 255 clocks.
3. Saturation: value_i=-37 in RUN → OFF at next boundary, duty_o=0. value_i=255 → duty_o=255 and pwm_o never low. value_i=19 → OFF; value_i=20 → KICK then RUN with duty 20.
4. Mid-period change: in RUN at duty 100, set value_i=200 at cnt=50. The current period still has 100 high clocks; the next period has 200.
5. Disable: drop enable_i during KICK at cnt=10 → next clock pwm_o=0, state OFF. Re-assert → KICK restarts at the next boundary with the full 2 periods.
6. CLK_DIV=4, KICK_PERIODS=0, value_i=64 → direct OFF→RUN. Period is 1020 clocks, pwm_o high for 256 clocks, period_end_o pulses every 1020 clocks.

Source files
------------

// File: rtl/pwm_fan_driver_pkg.sv
// Shared definitions for the fan PWM output stage.
// Holds the OFF/KICK/RUN state encoding and the PWM period length helper.
// Imported by pwm_timebase and pwm_fan_driver.
package pwm_fan_driver_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_KICK = 2'b01,
    ST_RUN  = 2'b10
  } fan_state_e;

  // Ticks per PWM period. A full-scale duty of 2^bits-1 then keeps the pin
  // high on every tick of the period.
  function automatic int period_len(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Free-running PWM timebase: a clock prescaler feeding a period counter.
// Ports: clk_i/rstn_i; tick (last clock of a tick), cnt (position in period),
// boundary (last clock of period), plus next-cycle cnt/boundary for registered outputs.
module pwm_timebase
  import pwm_fan_driver_pkg::*;
#(
  parameter int ADC_BITWIDTH = 8,
  parameter int CLK_DIV      = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  output logic                    tick,
  output logic [ADC_BITWIDTH-1:0] cnt,
  output logic                    boundary,
  output logic [ADC_BITWIDTH-1:0] cnt_nxt,
  output logic                    boundary_nxt
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [ADC_BITWIDTH-1:0] CNT_LAST =
    ADC_BITWIDTH'(period_len(ADC_BITWIDTH) - 1);

  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;

  assign tick     = (pre == PRE_LAST);
  assign boundary = tick && (cnt == CNT_LAST);

  always_comb begin
    pre_nxt = pre + 1'b1;
    cnt_nxt = cnt;
    if (tick) begin
      pre_nxt = '0;
      cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Lookahead lets the parent register period_end so that it lines up
  // with the boundary clock instead of trailing it by one cycle.
  assign boundary_nxt = (pre_nxt == PRE_LAST) && (cnt_nxt == CNT_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= pre_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pwm_fan_driver.sv
// Fan PWM driver: saturates the signed PID output to a duty, applies it only at
// period boundaries, and forces full duty for KICK_PERIODS periods when starting.
// Ports: clk_i/rstn_i, enable_i, value_i in; pwm_o, duty_o, period_end_o, state_o out.
module pwm_fan_driver
  import pwm_fan_driver_pkg::*;
#(
  parameter int ADC_BITWIDTH = 8,
  parameter int CLK_DIV      = 4,
  parameter int KICK_PERIODS = 16,
  parameter int MIN_DUTY     = 20
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    enable_i,
  input  logic signed [ADC_BITWIDTH:0] value_i,
  output logic                    pwm_o,
  output logic [ADC_BITWIDTH-1:0] duty_o,
  output logic                    period_end_o,
  output logic [1:0]              state_o
);

  localparam int N  = ADC_BITWIDTH;
  localparam int KW = (KICK_PERIODS > 2) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [N-1:0]  FULL      = '1;
  localparam logic [N-1:0]  MIN_D     = N'(MIN_DUTY);
  localparam logic [KW-1:0] KICK_LOAD = KW'((KICK_PERIODS > 0) ? KICK_PERIODS - 1 : 0);

  logic          tick;
  logic          boundary;
  logic [N-1:0]  cnt;
  logic [N-1:0]  cnt_nxt;
  logic          boundary_nxt;

  fan_state_e    state;
  fan_state_e    state_nxt;
  logic [N-1:0]  duty_nxt;
  logic [KW-1:0] kick_cnt;
  logic [KW-1:0] kick_nxt;
  logic [N-1:0]  sat;
  logic          want_on;
  logic          at_end;

  pwm_timebase #(
    .ADC_BITWIDTH (ADC_BITWIDTH),
    .CLK_DIV      (CLK_DIV)
  ) u_timebase (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .tick         (tick),
    .cnt          (cnt),
    .boundary     (boundary),
    .cnt_nxt      (cnt_nxt),
    .boundary_nxt (boundary_nxt)
  );

  // Negative controller output clamps to zero; the sign bit clear means the
  // low N bits already are the duty.
  assign sat     = value_i[N] ? '0 : value_i[N-1:0];
  assign want_on = enable_i && (sat >= MIN_D);
  assign at_end  = tick && boundary;
  assign state_o = state;

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_o;
    kick_nxt  = kick_cnt;
    if (!enable_i) begin
      // Disable acts immediately, independent of the period boundary.
      state_nxt = ST_OFF;
      duty_nxt  = '0;
      kick_nxt  = '0;
    end else if (at_end) begin
      case (state)
        ST_OFF: begin
          if (want_on) begin
            if (KICK_PERIODS > 0) begin
              state_nxt = ST_KICK;
              kick_nxt  = KICK_LOAD;
              duty_nxt  = FULL;
            end else begin
              state_nxt = ST_RUN;
              duty_nxt  = sat;
            end
          end
        end
        ST_KICK: begin
          if (kick_cnt != '0) begin
            kick_nxt = kick_cnt - 1'b1;
          end else if (want_on) begin
            state_nxt = ST_RUN;
            duty_nxt  = sat;
          end else begin
            state_nxt = ST_OFF;
            duty_nxt  = '0;
          end
        end
        ST_RUN: begin
          if (want_on) begin
            duty_nxt = sat;
          end else begin
            state_nxt = ST_OFF;
            duty_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ST_OFF;
          duty_nxt  = '0;
          kick_nxt  = '0;
        end
      endcase
    end
  end

  // pwm_o and period_end_o are registered from next-cycle values so that they
  // match the cnt/duty held in the same cycle rather than lagging by one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= ST_OFF;
      duty_o       <= '0;
      kick_cnt     <= '0;
      pwm_o        <= 1'b0;
      period_end_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      duty_o       <= duty_nxt;
      kick_cnt     <= kick_nxt;
      pwm_o        <= (cnt_nxt < duty_nxt);
      period_end_o <= boundary_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_fan_driver.sv
// Directed bench for pwm_fan_driver: instance a (CLK_DIV=1, KICK=2) covers reset,
// kick, saturation, glitch-free updates and disable; instance b (CLK_DIV=4, KICK=0)
// covers direct start and the divided timebase.
module tb_pwm_fan_driver;

  logic              clk = 1'b0;
  logic              rstn_a, rstn_b;
  logic              en_a, en_b;
  logic signed [8:0] val_a, val_b;
  logic              pwm_a, pwm_b;
  logic [7:0]        duty_a, duty_b;
  logic              pe_a, pe_b;
  logic [1:0]        st_a, st_b;

  int checks = 0;
  int errors = 0;
  int hi, pe, h1, h2;

  always #5 clk = ~clk;

  pwm_fan_driver #(
    .ADC_BITWIDTH (8), .CLK_DIV (1), .KICK_PERIODS (2), .MIN_DUTY (20)
  ) dut_a (
    .clk_i (clk), .rstn_i (rstn_a), .enable_i (en_a), .value_i (val_a),
    .pwm_o (pwm_a), .duty_o (duty_a), .period_end_o (pe_a), .state_o (st_a)
  );

  pwm_fan_driver #(
    .ADC_BITWIDTH (8), .CLK_DIV (4), .KICK_PERIODS (0), .MIN_DUTY (20)
  ) dut_b (
    .clk_i (clk), .rstn_i (rstn_b), .enable_i (en_b), .value_i (val_b),
    .pwm_o (pwm_b), .duty_o (duty_b), .period_end_o (pe_b), .state_o (st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic count_win(input int n, input bit sel_b, output int h, output int p);
    h = 0;
    p = 0;
    for (int i = 0; i < n; i++) begin
      if (sel_b) begin
        h += int'(pwm_b);
        p += int'(pe_b);
      end else begin
        h += int'(pwm_a);
        p += int'(pe_a);
      end
      step(1);
    end
  endtask

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    en_a = 1'b1;   en_b = 1'b1;
    val_a = 9'sd100;
    val_b = 9'sd64;
    step(3);
    chk("reset_state",  st_a,   0);
    chk("reset_duty",   duty_a, 0);
    chk("reset_pwm",    pwm_a,  0);
    chk("reset_pe",     pe_a,   0);
    chk("reset_state_b", st_b,  0);

    // Run into KICK, then hit reset asynchronously mid-period.
    rstn_a = 1'b1;
    step(300);
    chk("pre_reset_kick_state", st_a,  1);
    chk("pre_reset_kick_pwm",   pwm_a, 1);
    #2 rstn_a = 1'b0;
    #1;
    chk("async_rst_state", st_a,   0);
    chk("async_rst_duty",  duty_a, 0);
    chk("async_rst_pwm",   pwm_a,  0);
    step(2);
    rstn_a = 1'b1;                   // k = 0

    // Test 1: OFF until the first boundary 255 clocks later.
    step(1);
    chk("t1_k1_state", st_a, 0);
    step(252);                       // k = 253
    chk("t1_k253_pe",    pe_a, 0);
    chk("t1_k253_state", st_a, 0);
    step(1);                         // k = 254
    chk("t1_k254_pe",    pe_a,  1);
    chk("t1_k254_state", st_a,  0);
    chk("t1_k254_pwm",   pwm_a, 0);
    step(1);                         // k = 255
    chk("t1_k255_pe",    pe_a,   0);
    chk("t2_kick_state", st_a,   1);
    chk("t2_kick_duty",  duty_a, 255);
    chk("t2_kick_pwm",   pwm_a,  1);

    // Test 2: two full-high kick periods, then RUN at 100.
    count_win(510, 1'b0, hi, pe);    // k = 765
    chk("t2_kick_high", hi, 510);
    chk("t2_kick_pe",   pe, 2);
    chk("t2_run_state", st_a,   2);
    chk("t2_run_duty",  duty_a, 100);
    count_win(255, 1'b0, hi, pe);    // k = 1020
    chk("t2_run_high", hi, 100);
    chk("t2_run_pe",   pe, 1);

    // Test 4: value change at cnt=50 only affects the next period.
    count_win(50, 1'b0, h1, pe);
    val_a = 9'sd200;
    chk("t4_duty_held", duty_a, 100);
    count_win(205, 1'b0, h2, pe);    // k = 1275
    chk("t4_cur_high",  h1 + h2, 100);
    chk("t4_next_duty", duty_a, 200);
    count_win(255, 1'b0, hi, pe);    // k = 1530
    chk("t4_next_high", hi, 200);

    // Test 3: saturation and the minimum-duty threshold.
    val_a = -9'sd37;
    step(255);                       // k = 1785
    chk("t3_neg_state", st_a,   0);
    chk("t3_neg_duty",  duty_a, 0);
    chk("t3_neg_pwm",   pwm_a,  0);
    val_a = 9'sd255;
    step(765);                       // k = 2550
    chk("t3_full_state", st_a,   2);
    chk("t3_full_duty",  duty_a, 255);
    count_win(255, 1'b0, hi, pe);    // k = 2805
    chk("t3_full_high", hi, 255);
    val_a = 9'sd19;
    step(255);                       // k = 3060
    chk("t3_19_state", st_a,   0);
    chk("t3_19_duty",  duty_a, 0);
    val_a = 9'sd20;
    step(255);                       // k = 3315
    chk("t3_20_kick_state", st_a,   1);
    chk("t3_20_kick_duty",  duty_a, 255);
    step(510);                       // k = 3825
    chk("t3_20_run_state", st_a,   2);
    chk("t3_20_run_duty",  duty_a, 20);
    count_win(255, 1'b0, hi, pe);    // k = 4080
    chk("t3_20_high", hi, 20);

    // Test 5: disable acts on the next clock; re-enable restarts the full kick.
    en_a = 1'b0;
    step(1);                         // k = 4081
    chk("t5_run_dis_state", st_a,   0);
    chk("t5_run_dis_pwm",   pwm_a,  0);
    chk("t5_run_dis_duty",  duty_a, 0);
    en_a = 1'b1;
    step(254);                       // k = 4335
    chk("t5_kick_state", st_a, 1);
    step(10);                        // k = 4345, cnt = 10
    en_a = 1'b0;
    step(1);
    chk("t5_kick_dis_pwm",   pwm_a,  0);
    chk("t5_kick_dis_state", st_a,   0);
    chk("t5_kick_dis_duty",  duty_a, 0);
    en_a = 1'b1;
    step(243);                       // k = 4589
    chk("t5_wait_state", st_a, 0);
    chk("t5_wait_pe",    pe_a, 1);
    step(1);                         // k = 4590
    chk("t5_rekick_state", st_a, 1);
    step(509);                       // k = 5099
    chk("t5_rekick_last", st_a, 1);
    step(1);                         // k = 5100
    chk("t5_rerun_state", st_a,   2);
    chk("t5_rerun_duty",  duty_a, 20);

    // Test 6: CLK_DIV=4, no kick, direct OFF->RUN.
    rstn_b = 1'b1;                   // j = 0
    step(1018);
    chk("t6_j1018_pe", pe_b, 0);
    step(1);
    chk("t6_j1019_pe",    pe_b, 1);
    chk("t6_j1019_state", st_b, 0);
    step(1);                         // j = 1020
    chk("t6_run_state", st_b,   2);
    chk("t6_run_duty",  duty_b, 64);
    chk("t6_run_pe",    pe_b,   0);
    count_win(1020, 1'b1, hi, pe);
    chk("t6_high", hi, 256);
    chk("t6_pe",   pe, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
